float2fixed_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision to signed fixed-point converter with valid/ready streaming handshake.
- Inverse neighbour of fixed2float. It sits upstream of it in loop-back datapaths, and on the egress side of float compute kernels that feed fixed-point consumers.
- Output is a 32-bit two's-complement value with FRAC_BITS fractional bits.
- Out-of-range and special inputs saturate, with sticky status.

---
 rtl/float_pkg.sv | 38 +++
 rtl/float2fixed_align.sv | 56 +++++
 rtl/float2fixed_pipe.sv | 179 +++++++++++++++++
 tb/tb_float2fixed_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision types and helpers for the float<->fixed converters.
// Holds field widths, the unpacked layout and the operand classification.
// Used by float2fixed_pipe, float2fixed_align and fixed2float.
package float_pkg;

    localparam int F32_EXP_BIAS = 127;
    localparam int F32_MANT_W   = 23;
    localparam int F32_EXP_W    = 8;

    typedef struct packed {
        logic                  sign;
        logic [F32_EXP_W-1:0]  exp;
        logic [F32_MANT_W-1:0] mant;
    } f32_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } f32_class_t;

    // Zero and denormals both map to ZERO: denormals are far below any
    // representable fixed-point step, so they are flushed.
    function automatic f32_class_t f32_classify(input logic [F32_EXP_W-1:0]  exp,
                                                input logic [F32_MANT_W-1:0] mant);
        f32_class_t cls;
        if (exp == '0) begin
            cls = ZERO;
        end else if (exp == '1) begin
            cls = (mant == '0) ? INF : NAN;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/float2fixed_align.sv
// Aligns a normal float mantissa to the fixed-point grid (magnitude, guard, sticky, overflow).
// Latency: purely combinational, no registers.
// Backpressure: none; the caller registers the outputs under its own enable.
module float2fixed_align
    import float_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  f32_class_t  cls,
    input  logic [7:0]  exp,
    input  logic [23:0] mant,
    output logic [31:0] mag,
    output logic        guard,
    output logic        sticky,
    output logic        ovf
);

    // Binary point of the result relative to the mantissa LSB:
    // shift = exp - bias - mantissa width + FRAC_BITS.
    localparam logic signed [9:0] SHIFT_OFS = 10'(FRAC_BITS - F32_EXP_BIAS - F32_MANT_W);

    logic signed [9:0] shift;
    logic [9:0]        rshift;
    logic [49:0]       wide;

    // Left shift for large exponents, right shift with guard/sticky capture otherwise.
    always_comb begin
        shift  = $signed({2'b00, exp}) + SHIFT_OFS;
        rshift = -shift;
        wide   = '0;
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        ovf    = 1'b0;
        if (cls == NORMAL) begin
            if (shift >= 10'sd0) begin
                // A 24-bit mantissa shifted by up to 8 still fits in 32 bits,
                // so beyond 8 the integer part is certainly lost.
                if (shift > 10'sd8) begin
                    ovf = 1'b1;
                end else begin
                    mag = {8'b0, mant} << shift[3:0];
                end
            end else if (rshift >= 10'd26) begin
                // Everything including the guard position is shifted out.
                sticky = 1'b1;
            end else begin
                wide   = {mant, 26'b0} >> rshift[4:0];
                mag    = {8'b0, wide[49:26]};
                guard  = wide[25];
                sticky = |wide[24:0];
            end
        end
    end

endmodule

// File: rtl/float2fixed_pipe.sv
// Converts IEEE-754 single to saturating signed Q(31-FRAC_BITS).FRAC_BITS fixed point.
// Latency: 3 register stages (unpack, align, round/saturate); 1 word per cycle.
// Backpressure: each stage loads when empty or when the next stage advances; s_ready = stage-1 enable.
module float2fixed_pipe
    import float_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_ovf,
    output logic             m_inv,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             cnt_clr
);

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

    f32_t       in_f;
    f32_class_t in_cls;

    logic en1, en2, en3;

    // Stage 1: unpacked operand
    logic        v1;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;
    f32_class_t  s1_cls;

    // Stage 2: aligned magnitude
    logic        v2;
    logic        s2_sign;
    f32_class_t  s2_cls;
    logic [31:0] s2_mag;
    logic        s2_guard;
    logic        s2_ovf;

    // Align outputs
    logic [31:0] al_mag;
    logic        al_guard;
    logic        al_ovf;
    logic        al_sticky_unused;

    // Stage 3 combinational result
    logic [32:0] rounded;
    logic [31:0] nxt_data;
    logic        nxt_ovf;
    logic        nxt_inv;

    assign in_f   = f32_t'(s_data);
    assign in_cls = f32_classify(in_f.exp, in_f.mant);

    // Enable chain runs back from the output; s_ready never depends on s_valid.
    assign en3     = !m_valid || m_ready;
    assign en2     = !v2 || en3;
    assign en1     = !v1 || en2;
    assign s_ready = aresetn && en1;

    // Stage 1: register sign, exponent and mantissa with the hidden bit restored.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_cls  <= ZERO;
        end else if (en1) begin
            v1 <= s_valid;
            if (s_valid) begin
                s1_sign <= in_f.sign;
                s1_exp  <= in_f.exp;
                s1_mant <= {1'b1, in_f.mant};
                s1_cls  <= in_cls;
            end
        end
    end

    // Ties-away rounding only needs the guard bit; sticky is left for other modes.
    float2fixed_align #(
        .FRAC_BITS (FRAC_BITS)
    ) u_align (
        .cls    (s1_cls),
        .exp    (s1_exp),
        .mant   (s1_mant),
        .mag    (al_mag),
        .guard  (al_guard),
        .sticky (al_sticky_unused),
        .ovf    (al_ovf)
    );

    // Stage 2: register the aligned magnitude and left-shift overflow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v2       <= 1'b0;
            s2_sign  <= 1'b0;
            s2_cls   <= ZERO;
            s2_mag   <= '0;
            s2_guard <= 1'b0;
            s2_ovf   <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign  <= s1_sign;
                s2_cls   <= s1_cls;
                s2_mag   <= al_mag;
                s2_guard <= al_guard;
                s2_ovf   <= al_ovf;
            end
        end
    end

    // Stage 3 logic: round half away from zero, saturate asymmetrically, apply sign.
    always_comb begin
        rounded  = {1'b0, s2_mag} + {32'b0, s2_guard};
        nxt_data = '0;
        nxt_ovf  = 1'b0;
        nxt_inv  = 1'b0;
        case (s2_cls)
            NAN: begin
                nxt_inv = 1'b1;
            end
            INF: begin
                nxt_ovf  = 1'b1;
                nxt_data = s2_sign ? SAT_NEG : SAT_POS;
            end
            NORMAL: begin
                // Negative side reaches one step further: -2^31 is representable.
                if (s2_ovf || (s2_sign ? (rounded > 33'h0_8000_0000)
                                       : (rounded > 33'h0_7FFF_FFFF))) begin
                    nxt_ovf  = 1'b1;
                    nxt_data = s2_sign ? SAT_NEG : SAT_POS;
                end else begin
                    nxt_data = s2_sign ? -rounded[31:0] : rounded[31:0];
                end
            end
            default: begin
                nxt_data = '0;
            end
        endcase
    end

    // Stage 3: output register, held while the consumer stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ovf   <= 1'b0;
            m_inv   <= 1'b0;
        end else if (en3) begin
            m_valid <= v2;
            if (v2) begin
                m_data <= nxt_data;
                m_ovf  <= nxt_ovf;
                m_inv  <= nxt_inv;
            end
        end
    end

    // Saturation event counter: clear wins, otherwise count flagged transfers up to all-ones.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sat_cnt <= '0;
        end else if (cnt_clr) begin
            sat_cnt <= '0;
        end else if (m_valid && m_ready && (m_ovf || m_inv) && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_float2fixed_pipe.sv
// Directed-vector bench for float2fixed_pipe with a real-arithmetic reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A scoreboard queue checks every output transfer; literal expectations pin the model.
module tb_float2fixed_pipe;

    localparam int FRAC_BITS = 16;
    localparam int CNT_W     = 3;

    logic             aclk    = 1'b0;
    logic             aresetn = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [31:0]      s_data  = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [31:0]      m_data;
    logic             m_ovf;
    logic             m_inv;
    logic [CNT_W-1:0] sat_cnt;
    logic             cnt_clr = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int out_cnt     = 0;

    logic [33:0] expq[$];
    logic        held_vld = 1'b0;
    logic [33:0] held     = '0;

    float2fixed_pipe #(
        .FRAC_BITS (FRAC_BITS),
        .CNT_W     (CNT_W)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_ovf   (m_ovf),
        .m_inv   (m_inv),
        .sat_cnt (sat_cnt),
        .cnt_clr (cnt_clr)
    );

    always #5 aclk = ~aclk;

    // Reference: value * 2^FRAC_BITS, rounded half away from zero, clipped to int32.
    // Result packing is {inv, ovf, data}.
    function automatic logic [33:0] model(input logic [31:0] f);
        int          ei;
        real         x;
        real         y;
        longint      mag;
        logic [31:0] d;
        ei = int'(f[30:23]);
        if (ei == 0) return '0;
        if (ei == 255) begin
            if (f[22:0] != 0) return {2'b10, 32'h0};
            return {2'b01, (f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        end
        x = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(ei - 127 + FRAC_BITS));
        y = $floor(x + 0.5);
        if (y > (f[31] ? 2147483648.0 : 2147483647.0))
            return {2'b01, (f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        mag = longint'(y);
        d   = 32'(f[31] ? -mag : mag);
        return {2'b00, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard and stall-stability monitor.
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                expq.delete();
                held_vld = 1'b0;
            end else begin
                if (held_vld)
                    check("stall_hold", {29'b0, m_valid, m_inv, m_ovf, m_data}, {29'b0, 1'b1, held});
                held_vld = m_valid && !m_ready;
                held     = {m_inv, m_ovf, m_data};
                if (m_valid && m_ready) begin
                    out_cnt++;
                    if (expq.size() == 0)
                        check("spurious_out", 64'(out_cnt), 64'(0));
                    else
                        check("model_out", {30'b0, m_inv, m_ovf, m_data}, {30'b0, expq.pop_front()});
                end
                if (s_valid && s_ready)
                    expq.push_back(model(s_data));
            end
        end
    end

    // One word into an empty pipe; result must appear exactly 3 cycles after acceptance.
    task automatic directed(input string name, input logic [31:0] f, input logic [31:0] d,
                            input logic o, input logic i);
        logic [63:0] lit;
        lit = {30'b0, i, o, d};
        check({name, "_model"}, {30'b0, model(f)}, lit);
        @(posedge aclk); #1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = f;
        check({name, "_accept"}, 64'(s_ready), 64'(1));
        @(posedge aclk); #1;
        s_valid = 1'b0;
        @(posedge aclk); #1;
        check({name, "_early"}, 64'(m_valid), 64'(0));
        @(posedge aclk); #1;
        check({name, "_lat3"}, {29'b0, m_valid, m_inv, m_ovf, m_data}, {29'b0, 1'b1, lit[33:0]});
    endtask

    // n copies of one word back-to-back with m_ready high, then drain.
    task automatic burst(input int n, input logic [31:0] w);
        int   sent;
        logic acc;
        sent    = 0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = w;
        for (int c = 0; c < n + 10 && sent < n; c++) begin
            @(negedge aclk);
            acc = s_valid && s_ready;
            @(posedge aclk); #1;
            if (acc) sent++;
            if (sent >= n) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        check("burst_accepted", 64'(sent), 64'(n));
        repeat (4) @(posedge aclk);
        #1;
    endtask

    logic [31:0] bp_words[5];

    initial begin
        int   idx;
        logic acc;

        #1;
        check("reset_state", {29'b0, s_ready, m_valid, m_ovf, m_inv, sat_cnt, m_data},
              64'(0));
        #22;
        aresetn = 1'b1;

        // Basic, boundary, special and rounding vectors.
        directed("pos_7_77",   32'h40f8a3d7, 32'h0007C51F, 1'b0, 1'b0);
        directed("neg_7_77",   32'hc0f8a3d7, 32'hFFF83AE1, 1'b0, 1'b0);
        directed("neg_32768",  32'hC7000000, 32'h80000000, 1'b0, 1'b0);
        directed("pos_32768",  32'h47000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        directed("one_e6",     32'h49742400, 32'h7FFFFFFF, 1'b1, 1'b0);
        directed("pos_inf",    32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
        directed("neg_inf",    32'hFF800000, 32'h80000000, 1'b1, 1'b0);
        directed("qnan",       32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
        directed("denormal",   32'h00000001, 32'h00000000, 1'b0, 1'b0);
        directed("neg_zero",   32'h80000000, 32'h00000000, 1'b0, 1'b0);
        directed("tie_pos",    32'h37000000, 32'h00000001, 1'b0, 1'b0);
        directed("tie_neg",    32'hB7000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        directed("below_half", 32'h36800000, 32'h00000000, 1'b0, 1'b0);
        directed("one",        32'h3F800000, 32'h00010000, 1'b0, 1'b0);

        // Five flagged transfers so far.
        check("sat_cnt_after_directed", 64'(sat_cnt), 64'(5));
        @(posedge aclk); #1;
        cnt_clr = 1'b1;
        @(posedge aclk); #1;
        cnt_clr = 1'b0;
        check("sat_cnt_clr", 64'(sat_cnt), 64'(0));

        // Backpressure: 6 stalled cycles while offering 5 words.
        bp_words[0] = 32'h3F800000;
        bp_words[1] = 32'hBF800000;
        bp_words[2] = 32'h40490FDB;
        bp_words[3] = 32'h42C80000;
        bp_words[4] = 32'hC2C80000;
        out_cnt = 0;
        idx     = 0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = bp_words[0];
        repeat (6) begin
            @(negedge aclk);
            acc = s_valid && s_ready;
            @(posedge aclk); #1;
            if (acc) idx++;
            if (idx < 5) s_data = bp_words[idx];
            else         s_valid = 1'b0;
        end
        check("bp_accepted", 64'(idx), 64'(3));
        check("bp_s_ready_low", 64'(s_ready), 64'(0));
        check("bp_no_out_while_stalled", 64'(out_cnt), 64'(0));
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            acc = s_valid && s_ready;
            check("bp_no_gap", 64'(m_valid), 64'(1));
            @(posedge aclk); #1;
            if (acc) idx++;
            if (idx < 5) s_data = bp_words[idx];
            else         s_valid = 1'b0;
        end
        s_valid = 1'b0;
        check("bp_all_accepted", 64'(idx), 64'(5));
        repeat (2) @(posedge aclk);
        #1;
        check("bp_out_count", 64'(out_cnt), 64'(5));
        check("bp_queue_empty", 64'(expq.size()), 64'(0));

        // Counter: three flagged words, then clear coinciding with a fourth.
        burst(3, 32'h7F800000);
        check("sat_cnt_three", 64'(sat_cnt), 64'(3));
        @(posedge aclk); #1;
        s_valid = 1'b1;
        s_data  = 32'hFF800000;
        @(posedge aclk); #1;
        s_valid = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        check("clr_race_valid", {62'b0, m_valid, m_ovf}, 64'h3);
        cnt_clr = 1'b1;
        @(posedge aclk); #1;
        cnt_clr = 1'b0;
        check("clr_beats_inc", 64'(sat_cnt), 64'(0));

        // Counter holds at all-ones.
        burst(9, 32'h7FC00000);
        check("sat_cnt_saturates", 64'(sat_cnt), 64'(7));

        // Reset in the middle of a stream.
        s_valid = 1'b1;
        s_data  = 32'hC7800000;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        @(posedge aclk); #2;
        aresetn = 1'b0;
        s_valid = 1'b0;
        #1;
        check("midreset_outputs", {29'b0, s_ready, m_valid, m_ovf, m_inv, sat_cnt, m_data},
              64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        idx = out_cnt;
        repeat (3) @(posedge aclk);
        #1;
        check("no_partial_after_reset", {63'b0, m_valid}, 64'(0));
        check("no_out_after_reset", 64'(out_cnt), 64'(idx));
        directed("post_reset", 32'h42C80000, 32'h00640000, 1'b0, 1'b0);

        @(posedge aclk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
